// File: rtl/rv32i_memaccess_if.sv
// -----------------------------------------------------------------------------
// rv32i_memaccess_if
// Pipelined Wishbone data-bus bundle between the memory-access stage and the
// data memory.
//   master : o_wb_cyc/stb/we/addr/data/sel out, i_wb_ack/stall/data in
//   slave  : mirror image of master
// -----------------------------------------------------------------------------
interface rv32i_memaccess_if;
   logic        o_wb_cyc;
   logic        o_wb_stb;
   logic        o_wb_we;
   logic [31:0] o_wb_addr;
   logic [31:0] o_wb_data;
   logic [3:0]  o_wb_sel;
   logic        i_wb_ack;
   logic        i_wb_stall;
   logic [31:0] i_wb_data;

   modport master (
      output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
      input  i_wb_ack, i_wb_stall, i_wb_data
   );

   modport slave (
      input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
      output i_wb_ack, i_wb_stall, i_wb_data
   );
endinterface

// File: rtl/rv32i_memaccess.sv
// -----------------------------------------------------------------------------
// rv32i_memaccess
// RV32I memory-access stage. Loads/stores run one pipelined Wishbone
// transaction with byte-lane steering and load extension; all other
// instructions pass through with one cycle of latency.
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_ce .. i_pc          registered execute-stage outputs
//   i_stall, i_flush      downstream stall, kill current instruction
//   bus (master)          Wishbone data bus
//   o_rd_addr .. o_pc     registered writeback-stage fields
//   o_misaligned          access was misaligned (no bus activity)
//   o_bus_err             ack timeout abort
//   o_ce                  next-stage valid
//   o_stall               combinational back-pressure to execute
// -----------------------------------------------------------------------------
module rv32i_memaccess #(
   parameter int ACK_TIMEOUT  = 255,
   parameter int OPCODE_WIDTH = 11,
   parameter int OP_STORE     = 5
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_ce,
   input  logic                    i_stall_from_alu,
   input  logic [31:0]             i_y,
   input  logic [31:0]             i_rs2,
   input  logic [2:0]              i_funct3,
   input  logic [OPCODE_WIDTH-1:0] i_opcode,
   input  logic [4:0]              i_rd_addr,
   input  logic [31:0]             i_rd,
   input  logic                    i_rd_valid,
   input  logic                    i_wr_rd,
   input  logic [31:0]             i_pc,
   input  logic                    i_stall,
   input  logic                    i_flush,
   rv32i_memaccess_if.master       bus,
   output logic [4:0]              o_rd_addr,
   output logic [31:0]             o_rd,
   output logic                    o_rd_valid,
   output logic                    o_wr_rd,
   output logic [2:0]              o_funct3,
   output logic [OPCODE_WIDTH-1:0] o_opcode,
   output logic [31:0]             o_pc,
   output logic                    o_misaligned,
   output logic                    o_bus_err,
   output logic                    o_ce,
   output logic                    o_stall
);

   typedef enum logic [1:0] {IDLE, BUS, WAIT} state_t;

   // Counter only has to reach ACK_TIMEOUT-1: the abort happens on that cycle.
   localparam int            CW      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

   state_t                  state_q;
   logic [CW-1:0]           cnt_q;
   logic                    cyc_q, stb_q, we_q;
   logic [31:0]             addr_q, wdat_q;
   logic [3:0]              sel_q;
   logic [4:0]              rd_addr_q;
   logic [31:0]             rd_q, pc_q;
   logic                    rd_valid_q, wr_rd_q, mis_q, err_q, ce_q;
   logic [2:0]              funct3_q;
   logic [OPCODE_WIDTH-1:0] opcode_q;

   logic [1:0]  a;
   logic        misaligned, memop, to_hit;
   logic [3:0]  sel_d;
   logic [31:0] wdat_d, ld_val;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic        fin_d, rd_valid_d, wr_rd_d, mis_d, err_d;
   logic [31:0] rd_d;

   assign a          = i_y[1:0];
   // funct3[1:0]: 00 byte, 01 half, 1x word
   assign misaligned = i_stall_from_alu &
                       (((i_funct3[1:0] == 2'b01) & a[0]) | (i_funct3[1] & (a != 2'b00)));
   assign memop      = i_ce & i_stall_from_alu & ~i_flush & ~misaligned & ~i_stall;
   assign to_hit     = (ACK_TIMEOUT != 0) && (cnt_q == TO_LAST);

   assign o_stall = i_stall | ((state_q != IDLE) & ~bus.i_wb_ack) | ((state_q == IDLE) & memop);

   // Store steering and load lane extraction (execute holds i_y until ack)
   always_comb begin
      sel_d  = 4'b1111;
      wdat_d = i_rs2;
      ld_b   = bus.i_wb_data[{a, 3'b000} +: 8];
      ld_h   = a[1] ? bus.i_wb_data[31:16] : bus.i_wb_data[15:0];
      ld_val = bus.i_wb_data;
      case (i_funct3[1:0])
         2'b00: begin
            sel_d  = 4'b0001 << a;
            wdat_d = {4{i_rs2[7:0]}};
            ld_val = {{24{~i_funct3[2] & ld_b[7]}}, ld_b};
         end
         2'b01: begin
            sel_d  = a[1] ? 4'b1100 : 4'b0011;
            wdat_d = {2{i_rs2[15:0]}};
            ld_val = {{16{~i_funct3[2] & ld_h[15]}}, ld_h};
         end
         default: ;
      endcase
   end

   // Completion detect and result selection
   always_comb begin
      fin_d      = 1'b0;
      rd_d       = i_rd;
      rd_valid_d = i_rd_valid;
      wr_rd_d    = i_wr_rd;
      mis_d      = 1'b0;
      err_d      = 1'b0;
      if (state_q == IDLE) begin
         if (i_ce & ~i_flush & ~i_stall_from_alu) begin
            fin_d = 1'b1;
         end else if (i_ce & ~i_flush & misaligned) begin
            fin_d      = 1'b1;
            rd_d       = i_y;
            rd_valid_d = 1'b0;
            wr_rd_d    = 1'b0;
            mis_d      = 1'b1;
         end
      end else if (~i_flush) begin
         // flush beats a same-cycle ack; ack beats the timeout
         if (bus.i_wb_ack) begin
            fin_d      = 1'b1;
            rd_d       = we_q ? 32'd0 : ld_val;
            rd_valid_d = ~we_q;
            wr_rd_d    = ~we_q;
         end else if (to_hit) begin
            fin_d      = 1'b1;
            rd_d       = 32'd0;
            rd_valid_d = 1'b0;
            wr_rd_d    = 1'b0;
            err_d      = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cyc_q      <= 1'b0;
         stb_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdat_q     <= '0;
         sel_q      <= '0;
         rd_addr_q  <= '0;
         rd_q       <= '0;
         rd_valid_q <= 1'b0;
         wr_rd_q    <= 1'b0;
         funct3_q   <= '0;
         opcode_q   <= '0;
         pc_q       <= '0;
         mis_q      <= 1'b0;
         err_q      <= 1'b0;
         ce_q       <= 1'b0;
      end else if (!i_stall) begin
         ce_q <= fin_d;
         if (fin_d) begin
            rd_addr_q  <= i_rd_addr;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            wr_rd_q    <= wr_rd_d;
            funct3_q   <= i_funct3;
            opcode_q   <= i_opcode;
            pc_q       <= i_pc;
            mis_q      <= mis_d;
            err_q      <= err_d;
         end
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (memop) begin
                  state_q <= BUS;
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  we_q    <= i_opcode[OP_STORE];
                  addr_q  <= {i_y[31:2], 2'b00};
                  sel_q   <= sel_d;
                  wdat_q  <= wdat_d;
               end
            end
            default: begin
               if (i_flush || fin_d) begin
                  state_q <= IDLE;
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (state_q == BUS && !bus.i_wb_stall) begin
                     stb_q   <= 1'b0;
                     state_q <= WAIT;
                  end
               end
            end
         endcase
      end
   end

   assign bus.o_wb_cyc  = cyc_q;
   assign bus.o_wb_stb  = stb_q;
   assign bus.o_wb_we   = we_q;
   assign bus.o_wb_addr = addr_q;
   assign bus.o_wb_data = wdat_q;
   assign bus.o_wb_sel  = sel_q;

   assign o_rd_addr    = rd_addr_q;
   assign o_rd         = rd_q;
   assign o_rd_valid   = rd_valid_q;
   assign o_wr_rd      = wr_rd_q;
   assign o_funct3     = funct3_q;
   assign o_opcode     = opcode_q;
   assign o_pc         = pc_q;
   assign o_misaligned = mis_q;
   assign o_bus_err    = err_q;
   assign o_ce         = ce_q;

endmodule

// File: tb/tb_rv32i_memaccess.sv
// -----------------------------------------------------------------------------
// tb_rv32i_memaccess
// Self-checking bench: directed cases plus randomized load/store/ALU traffic
// against a small arithmetic reference model of the stage.
// -----------------------------------------------------------------------------
module tb_rv32i_memaccess;
   localparam int OPW      = 11;
   localparam int OP_ALU   = 2;
   localparam int OP_LOAD  = 4;
   localparam int OP_STORE = 5;
   localparam int TO       = 4;

   logic            clk = 1'b0;
   logic            rst_n, ce, sfa, stall, flush, rd_valid, wr_rd;
   logic [31:0]     y, rs2, rd, pc;
   logic [2:0]      f3;
   logic [OPW-1:0]  opc;
   logic [4:0]      rd_addr;
   logic [4:0]      o_rd_addr;
   logic [31:0]     o_rd, o_pc;
   logic            o_rd_valid, o_wr_rd, o_mis, o_err, o_ce, o_stall;
   logic [2:0]      o_funct3;
   logic [OPW-1:0]  o_opcode;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rv32i_memaccess_if bus();

   rv32i_memaccess #(.ACK_TIMEOUT(TO), .OPCODE_WIDTH(OPW), .OP_STORE(OP_STORE)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_stall_from_alu(sfa),
      .i_y(y), .i_rs2(rs2), .i_funct3(f3), .i_opcode(opc),
      .i_rd_addr(rd_addr), .i_rd(rd), .i_rd_valid(rd_valid), .i_wr_rd(wr_rd),
      .i_pc(pc), .i_stall(stall), .i_flush(flush), .bus(bus),
      .o_rd_addr(o_rd_addr), .o_rd(o_rd), .o_rd_valid(o_rd_valid),
      .o_wr_rd(o_wr_rd), .o_funct3(o_funct3), .o_opcode(o_opcode), .o_pc(o_pc),
      .o_misaligned(o_mis), .o_bus_err(o_err), .o_ce(o_ce), .o_stall(o_stall)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference model: access size in bytes, lanes, and extension as arithmetic
   function automatic int unsigned acc_size(input logic [2:0] f);
      return 1 << f[1:0];
   endfunction

   function automatic logic [3:0] model_sel(input logic [2:0] f, input logic [31:0] a);
      logic [31:0] m;
      m = ((32'd1 << acc_size(f)) - 1) << (a % 4);
      return m[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f, input logic [31:0] d);
      case (acc_size(f))
         1:       return (d & 32'hFF) * 32'h0101_0101;
         2:       return (d & 32'hFFFF) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
      logic [31:0] v;
      v = w >> (8 * (a % 4));
      case (acc_size(f))
         1: begin
            v = v & 32'hFF;
            return f[2] ? v : (v ^ 32'h80) - 32'h80;
         end
         2: begin
            v = v & 32'hFFFF;
            return f[2] ? v : (v ^ 32'h8000) - 32'h8000;
         end
         default: return w;
      endcase
   endfunction

   task automatic alu_op(input logic [31:0] val);
      logic [4:0]  ra;
      logic [31:0] p;
      logic        rv, wr;
      ra = 5'($urandom); p = $urandom; rv = 1'($urandom); wr = 1'($urandom);
      ce = 1; sfa = 0; rd = val; rd_valid = rv; wr_rd = wr; rd_addr = ra; pc = p;
      opc = OPW'(1) << OP_ALU; y = $urandom; f3 = 3'($urandom);
      #1;
      chk("alu_stall", 32'(o_stall), 0);
      tick;
      chk("alu_ce", 32'(o_ce), 1);
      chk("alu_rd", o_rd, val);
      chk("alu_rdv", 32'(o_rd_valid), 32'(rv));
      chk("alu_wr", 32'(o_wr_rd), 32'(wr));
      chk("alu_rda", 32'(o_rd_addr), 32'(ra));
      chk("alu_pc", o_pc, p);
      chk("alu_mis", 32'(o_mis), 0);
      ce = 0;
   endtask

   // s = cycles the slave stalls the strobe, d = extra cycles from accept to ack
   task automatic mem_op(input bit st, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdata,
                         input int s, input int d);
      logic [4:0]  ra;
      logic [31:0] p;
      bit          mis;
      int          last;
      mis  = (a % acc_size(f)) != 0;
      last = s + 1 + d;
      ra = 5'($urandom); p = $urandom;
      ce = 1; sfa = 1; y = a; rs2 = wd; f3 = f; rd_addr = ra; pc = p;
      opc = st ? (OPW'(1) << OP_STORE) : (OPW'(1) << OP_LOAD);
      rd = $urandom; rd_valid = 1; wr_rd = !st;
      bus.i_wb_ack = 0; bus.i_wb_stall = 0;
      #1;
      if (mis) begin
         chk("mis_stall", 32'(o_stall), 0);
         tick;
         chk("mis_ce", 32'(o_ce), 1);
         chk("mis_flag", 32'(o_mis), 1);
         chk("mis_wr", 32'(o_wr_rd), 0);
         chk("mis_cyc", 32'(bus.o_wb_cyc), 0);
         chk("mis_pc", o_pc, p);
         ce = 0;
         return;
      end
      chk("req_stall", 32'(o_stall), 1);
      tick;
      chk("cyc", 32'(bus.o_wb_cyc), 1);
      chk("we", 32'(bus.o_wb_we), 32'(st));
      chk("addr", bus.o_wb_addr, a & ~32'd3);
      chk("sel", 32'(bus.o_wb_sel), 32'(model_sel(f, a)));
      if (st) chk("wdata", bus.o_wb_data, model_wdata(f, wd));
      chk("ce_busy", 32'(o_ce), 0);
      for (int k = 1; k <= last; k++) begin
         bus.i_wb_stall = (k <= s);
         bus.i_wb_ack   = (k == last);
         bus.i_wb_data  = rdata;
         #1;
         chk("stb", 32'(bus.o_wb_stb), 32'(k <= s + 1));
         chk("cyc_hold", 32'(bus.o_wb_cyc), 1);
         chk("busy_stall", 32'(o_stall), 32'(k != last));
         tick;
      end
      bus.i_wb_ack = 0; bus.i_wb_stall = 0;
      chk("done_ce", 32'(o_ce), 1);
      chk("done_cyc", 32'(bus.o_wb_cyc), 0);
      chk("done_wr", 32'(o_wr_rd), 32'(!st));
      chk("done_rdv", 32'(o_rd_valid), 32'(!st));
      if (!st) chk("load_rd", o_rd, model_load(f, a, rdata));
      chk("done_rda", 32'(o_rd_addr), 32'(ra));
      chk("done_pc", o_pc, p);
      chk("done_f3", 32'(o_funct3), 32'(f));
      chk("done_err", 32'(o_err), 0);
      chk("done_mis", 32'(o_mis), 0);
      ce = 0;
   endtask

   initial begin
      int cnt;
      logic [2:0] fsel;
      bit st;
      rst_n = 0; ce = 0; sfa = 0; stall = 0; flush = 0; rd_valid = 0; wr_rd = 0;
      y = 0; rs2 = 0; rd = 0; pc = 0; f3 = 0; opc = '0; rd_addr = 0;
      bus.i_wb_ack = 0; bus.i_wb_stall = 0; bus.i_wb_data = 0;
      tick; tick;
      chk("rst_cyc", 32'(bus.o_wb_cyc), 0);
      chk("rst_stb", 32'(bus.o_wb_stb), 0);
      chk("rst_ce", 32'(o_ce), 0);
      chk("rst_wr", 32'(o_wr_rd), 0);
      chk("rst_rdv", 32'(o_rd_valid), 0);
      chk("rst_stall", 32'(o_stall), 0);
      rst_n = 1;
      tick;

      // SW, ack on the 4th bus cycle (last one before timeout)
      mem_op(1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 3);
      // LB / LBU from the top lane
      mem_op(0, 3'd0, 32'h203, 32'h0, 32'h80123456, 0, 1);
      chk("lb_const", o_rd, 32'hFFFFFF80);
      mem_op(0, 3'd4, 32'h203, 32'h0, 32'h80123456, 1, 0);
      chk("lbu_const", o_rd, 32'h00000080);
      // SH with slave stalling the strobe for 2 cycles
      mem_op(1, 3'd1, 32'h102, 32'h1234, 32'h0, 2, 0);
      // Misaligned LW
      mem_op(0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 0);

      // ADD, LW, then LW flushed in WAIT with a late ack
      alu_op(32'd7);
      mem_op(0, 3'd2, 32'h40, 32'h0, 32'hCAFEF00D, 0, 0);
      ce = 1; sfa = 1; y = 32'h100; f3 = 3'd2; opc = OPW'(1) << OP_LOAD;
      #1;
      tick;
      tick;
      chk("wait_cyc", 32'(bus.o_wb_cyc), 1);
      chk("wait_stb", 32'(bus.o_wb_stb), 0);
      flush = 1;
      tick;
      chk("fl_cyc", 32'(bus.o_wb_cyc), 0);
      chk("fl_ce", 32'(o_ce), 0);
      flush = 0; ce = 0; bus.i_wb_ack = 1;
      #1;
      chk("late_stall", 32'(o_stall), 0);
      tick;
      chk("late_ce", 32'(o_ce), 0);
      chk("late_cyc", 32'(bus.o_wb_cyc), 0);
      bus.i_wb_ack = 0;

      // Timeout: no ack at all
      ce = 1; sfa = 1; y = 32'h300; f3 = 3'd2; opc = OPW'(1) << OP_LOAD; wr_rd = 1;
      #1;
      tick;
      cnt = 0;
      while (bus.o_wb_cyc && cnt < 10) begin
         cnt++;
         tick;
      end
      chk("to_cycles", 32'(cnt), 32'(TO));
      chk("to_ce", 32'(o_ce), 1);
      chk("to_err", 32'(o_err), 1);
      chk("to_wr", 32'(o_wr_rd), 0);
      ce = 0;
      tick;

      // Reset while a store is in BUS
      ce = 1; sfa = 1; y = 32'h500; rs2 = 32'h1; f3 = 3'd2; opc = OPW'(1) << OP_STORE;
      #1;
      tick;
      chk("rst_pre_cyc", 32'(bus.o_wb_cyc), 1);
      rst_n = 0;
      tick;
      chk("rstb_cyc", 32'(bus.o_wb_cyc), 0);
      chk("rstb_stb", 32'(bus.o_wb_stb), 0);
      chk("rstb_ce", 32'(o_ce), 0);
      rst_n = 1; ce = 0;
      tick;

      // Downstream stall holds the completed result
      alu_op(32'h55AA);
      stall = 1;
      #1;
      chk("st_ostall", 32'(o_stall), 1);
      tick;
      chk("st_ce_hold", 32'(o_ce), 1);
      chk("st_rd_hold", o_rd, 32'h55AA);
      stall = 0;
      tick;
      chk("st_ce_drop", 32'(o_ce), 0);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            alu_op($urandom);
         end else begin
            st = 1'($urandom);
            case ($urandom_range(0, st ? 2 : 4))
               0: fsel = 3'd0;
               1: fsel = 3'd1;
               2: fsel = 3'd2;
               3: fsel = 3'd4;
               default: fsel = 3'd5;
            endcase
            mem_op(st, fsel, $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
